// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

    localparam int LEN_W = 16;
    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HDR,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs accepted stream bytes into little-endian 32-bit words; word/word_valid are
// combinational so the caller can register them on the edge that takes the 4th byte.
module word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift;
    logic [1:0]  byte_cnt;

    // Only the first three bytes need storing; the fourth arrives with word_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift    <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            shift    <= '0;
            byte_cnt <= '0;
        end else if (byte_valid) begin
            shift    <= {byte_data, shift[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word       = {byte_data, shift};
    assign word_valid = byte_valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes instruction memory and holds the CPU
// in reset until a frame with a valid checksum has been fully loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W   = 8,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH = 1 << ADDR_W;

    loader_state_t     state, next_state;
    logic [7:0]        len_lo;
    logic [LEN_W-1:0]  words_left;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        csum_acc;
    logic [LEN_W:0]    len_req;
    logic              accept, enter_wait, pk_valid, word_valid, in_frame_next;
    logic [31:0]       pk_word;

    assign accept   = in_valid && in_ready;
    assign pk_valid = accept && (state == DATA);
    assign len_req  = {1'b0, in_data, len_lo};

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (enter_wait),
        .byte_valid (pk_valid),
        .byte_data  (in_data),
        .word       (pk_word),
        .word_valid (word_valid)
    );

    always_comb begin
        next_state = state;
        enter_wait = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    next_state = WAIT_HDR;
                    enter_wait = 1'b1;
                end
            end
            WAIT_HDR: if (accept && in_data == HDR_BYTE) next_state = LEN_LO;
            LEN_LO:   if (accept) next_state = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (len_req > (LEN_W+1)'(DEPTH))
                        next_state = ERROR;
                    else if (len_req == '0)
                        next_state = CSUM;
                    else
                        next_state = DATA;
                end
            end
            DATA:     if (word_valid && words_left == LEN_W'(1)) next_state = CSUM;
            CSUM:     if (accept) next_state = (in_data == csum_acc) ? DONE : ERROR;
            default:  next_state = IDLE;
        endcase
    end

    assign in_frame_next = next_state inside {WAIT_HDR, LEN_LO, LEN_HI, DATA, CSUM};

    // Status outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_rst_n    <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            addr_cnt     <= '0;
            words_left   <= '0;
            len_lo       <= '0;
            csum_acc     <= '0;
        end else begin
            state     <= next_state;
            in_ready  <= in_frame_next;
            busy      <= in_frame_next;
            mem_wr_en <= word_valid;
            if (enter_wait) begin
                cpu_rst_n    <= 1'b0;
                done         <= 1'b0;
                err          <= 1'b0;
                words_loaded <= '0;
                addr_cnt     <= '0;
                csum_acc     <= '0;
            end else begin
                if (next_state == IDLE)
                    cpu_rst_n <= 1'b1;
                if (accept && state inside {LEN_LO, LEN_HI, DATA})
                    csum_acc <= csum_acc ^ in_data;
                if (accept && state == LEN_LO)
                    len_lo <= in_data;
                if (accept && state == LEN_HI)
                    words_left <= len_req[LEN_W-1:0];
                if (word_valid) begin
                    mem_addr     <= addr_cnt;
                    mem_wdata    <= pk_word;
                    addr_cnt     <= addr_cnt + ADDR_W'(1);
                    words_loaded <= words_loaded + (ADDR_W+1)'(1);
                    words_left   <= words_left - LEN_W'(1);
                end
                if (state == CSUM && next_state == DONE) begin
                    done      <= 1'b1;
                    cpu_rst_n <= 1'b1;
                end
                if (state != ERROR && next_state == ERROR)
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a memory-write monitor.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  words_loaded;

    int checks = 0;
    int fails  = 0;

    logic [31:0] model_mem [256];
    int          wr_count  [256];
    int          wr_total  = 0;
    int          wr_double = 0;
    logic        prev_wr   = 1'b0;
    logic [7:0]  txq [$];

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image seen through the write port, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            model_mem[mem_addr] = mem_wdata;
            wr_count[mem_addr]  = wr_count[mem_addr] + 1;
            wr_total            = wr_total + 1;
            if (prev_wr) wr_double = wr_double + 1;
        end
        prev_wr = mem_wr_en;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 32'hDEAD_BEEF;
            wr_count[i]  = 0;
        end
        wr_total  = 0;
        wr_double = 0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        logic acc;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        acc      = 1'b0;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) checkOutput("byte_accept", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input int max_gap);
        while (txq.size() > 0) begin
            sendByte(txq.pop_front(), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    task automatic pushGoodFrame();
        txq.push_back(8'hA5); txq.push_back(8'h02); txq.push_back(8'h00);
        txq.push_back(8'h04); txq.push_back(8'h03); txq.push_back(8'h02); txq.push_back(8'h01);
        txq.push_back(8'h08); txq.push_back(8'h07); txq.push_back(8'h06); txq.push_back(8'h05);
        txq.push_back(8'h0A);
    endtask

    task automatic checkGoodResult(input string pfx);
        @(negedge clk);
        checkOutput({pfx, "_mem0"},  model_mem[0], 32'h0102_0304);
        checkOutput({pfx, "_mem1"},  model_mem[1], 32'h0506_0708);
        checkOutput({pfx, "_writes"}, 32'(wr_total), 32'd2);
        checkOutput({pfx, "_wr_pulse"}, 32'(wr_double), 32'd0);
        checkOutput({pfx, "_done"},  {31'd0, done}, 32'd1);
        checkOutput({pfx, "_err"},   {31'd0, err}, 32'd0);
        checkOutput({pfx, "_busy"},  {31'd0, busy}, 32'd0);
        checkOutput({pfx, "_ready"}, {31'd0, in_ready}, 32'd0);
        checkOutput({pfx, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd1);
        checkOutput({pfx, "_words"}, {23'd0, words_loaded}, 32'd2);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clearModel();

        // Reset values, then CPU released one edge after reset deasserts
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready",     {31'd0, in_ready}, 32'd0);
        checkOutput("rst_wr_en",     {31'd0, mem_wr_en}, 32'd0);
        checkOutput("rst_addr",      {24'd0, mem_addr}, 32'd0);
        checkOutput("rst_wdata",     mem_wdata, 32'd0);
        checkOutput("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        checkOutput("rst_busy",      {31'd0, busy}, 32'd0);
        checkOutput("rst_done",      {31'd0, done}, 32'd0);
        checkOutput("rst_err",       {31'd0, err}, 32'd0);
        checkOutput("rst_words",     {23'd0, words_loaded}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_cpu_before_edge", {31'd0, cpu_rst_n}, 32'd0);
        @(negedge clk);
        checkOutput("rel_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        checkOutput("rel_ready",     {31'd0, in_ready}, 32'd0);

        // Good two-word frame
        @(posedge clk); #1;
        clearModel();
        pulseStart();
        @(negedge clk);
        checkOutput("t2_busy_start", {31'd0, busy}, 32'd1);
        checkOutput("t2_cpu_held",   {31'd0, cpu_rst_n}, 32'd0);
        @(posedge clk); #1;
        pushGoodFrame();
        applyStimulus(0);
        checkGoodResult("t2");

        // Bad checksum, then recovery with a good frame
        @(posedge clk); #1;
        clearModel();
        pulseStart();
        pushGoodFrame();
        void'(txq.pop_back());
        txq.push_back(8'h0B);
        applyStimulus(0);
        @(negedge clk);
        checkOutput("t3_err",  {31'd0, err}, 32'd1);
        checkOutput("t3_done", {31'd0, done}, 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("t3_cpu_held", {31'd0, cpu_rst_n}, 32'd0);
        @(posedge clk); #1;
        clearModel();
        pulseStart();
        pushGoodFrame();
        applyStimulus(0);
        checkGoodResult("t3r");

        // Oversized length rejected at LEN_HI
        @(posedge clk); #1;
        clearModel();
        pulseStart();
        txq.push_back(8'hA5); txq.push_back(8'h01); txq.push_back(8'h01);
        applyStimulus(0);
        @(negedge clk);
        checkOutput("t4_err",    {31'd0, err}, 32'd1);
        checkOutput("t4_ready",  {31'd0, in_ready}, 32'd0);
        checkOutput("t4_cpu",    {31'd0, cpu_rst_n}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t4_writes", 32'(wr_total), 32'd0);

        // Junk before header, random gaps, and an ignored start mid-frame
        @(posedge clk); #1;
        clearModel();
        pulseStart();
        txq.push_back(8'h00); txq.push_back(8'hFF); txq.push_back(8'h5A);
        txq.push_back(8'hA5); txq.push_back(8'h02);
        applyStimulus(3);
        pulseStart();
        txq.push_back(8'h00);
        txq.push_back(8'h04); txq.push_back(8'h03); txq.push_back(8'h02); txq.push_back(8'h01);
        txq.push_back(8'h08); txq.push_back(8'h07); txq.push_back(8'h06); txq.push_back(8'h05);
        txq.push_back(8'h0A);
        applyStimulus(3);
        checkGoodResult("t5");

        // Zero-length frame: checksum covers only the length bytes
        @(posedge clk); #1;
        clearModel();
        pulseStart();
        txq.push_back(8'hA5); txq.push_back(8'h00); txq.push_back(8'h00); txq.push_back(8'h00);
        applyStimulus(0);
        @(negedge clk);
        checkOutput("n0_done",   {31'd0, done}, 32'd1);
        checkOutput("n0_words",  {23'd0, words_loaded}, 32'd0);
        checkOutput("n0_writes", 32'(wr_total), 32'd0);

        // Full-depth frame: word k holds k, payload XOR is 0 so CSUM = 0x01
        @(posedge clk); #1;
        clearModel();
        pulseStart();
        txq.push_back(8'hA5); txq.push_back(8'h00); txq.push_back(8'h01);
        for (int k = 0; k < 256; k++) begin
            txq.push_back(8'(k)); txq.push_back(8'h00); txq.push_back(8'h00); txq.push_back(8'h00);
        end
        txq.push_back(8'h01);
        applyStimulus(0);
        @(negedge clk);
        checkOutput("full_done",   {31'd0, done}, 32'd1);
        checkOutput("full_words",  {23'd0, words_loaded}, 32'd256);
        checkOutput("full_writes", 32'(wr_total), 32'd256);
        checkOutput("full_mem0",   model_mem[0], 32'd0);
        checkOutput("full_mem255", model_mem[255], 32'd255);

        // Reset mid-frame after five payload bytes
        @(posedge clk); #1;
        clearModel();
        pulseStart();
        txq.push_back(8'hA5); txq.push_back(8'h02); txq.push_back(8'h00);
        txq.push_back(8'h04); txq.push_back(8'h03); txq.push_back(8'h02); txq.push_back(8'h01);
        txq.push_back(8'h08);
        applyStimulus(0);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_busy",   {31'd0, busy}, 32'd0);
        checkOutput("t6_wr_en",  {31'd0, mem_wr_en}, 32'd0);
        checkOutput("t6_words",  {23'd0, words_loaded}, 32'd0);
        checkOutput("t6_ready",  {31'd0, in_ready}, 32'd0);
        checkOutput("t6_addr0_writes", 32'(wr_count[0]), 32'd1);
        checkOutput("t6_addr0_data",   model_mem[0], 32'h0102_0304);
        repeat (2) @(negedge clk);
        checkOutput("t6_writes", 32'(wr_total), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got 1 expected 0");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
